// File: rtl/clocks_gen_pkg.sv
// Shared constants and the effective-high-time rule for the clock generator.
package clocks_gen_pkg;

    localparam int NUM_CH_DEF = 4;
    localparam int CNT_W_DEF  = 32;
    localparam int CNT_W_MAX  = 64;

    typedef logic [CNT_W_MAX-1:0] cnt_max_t;

    // A width outside 1..period-1 falls back to 50% duty (floor).
    function automatic cnt_max_t eff_high(input cnt_max_t period, input cnt_max_t width);
        if (width != '0 && width < period) begin
            return width;
        end
        return period >> 1;
    endfunction

endpackage

// File: rtl/clocks_gen_if.sv
// Configuration bus for clocks_gen: per-channel period/width (and phase when
// CLOCKS_GEN_PHASE_EN is defined) values with their write strobes.
interface clocks_gen_if
    import clocks_gen_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CNT_W  = CNT_W_DEF
);
    logic [NUM_CH*CNT_W-1:0] period_i;
    logic [NUM_CH-1:0]       period_wstb_i;
    logic [NUM_CH*CNT_W-1:0] width_i;
    logic [NUM_CH-1:0]       width_wstb_i;
`ifdef CLOCKS_GEN_PHASE_EN
    logic [NUM_CH*CNT_W-1:0] phase_i;
    logic [NUM_CH-1:0]       phase_wstb_i;
`endif

    modport master (
        output period_i, period_wstb_i, width_i, width_wstb_i
`ifdef CLOCKS_GEN_PHASE_EN
        , output phase_i, phase_wstb_i
`endif
    );

    modport slave (
        input period_i, period_wstb_i, width_i, width_wstb_i
`ifdef CLOCKS_GEN_PHASE_EN
        , input phase_i, phase_wstb_i
`endif
    );

endinterface

// File: rtl/clocks_gen_chan.sv
// One clock channel: captured period/width (and phase under CLOCKS_GEN_PHASE_EN),
// a wrapping up-counter and the registered clock output.
module clocks_gen_chan
    import clocks_gen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             enable_i,
    input  logic             restart_all_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic             period_wstb_i,
    input  logic [CNT_W-1:0] width_i,
    input  logic             width_wstb_i,
`ifdef CLOCKS_GEN_PHASE_EN
    input  logic [CNT_W-1:0] phase_i,
    input  logic             phase_wstb_i,
`endif
    output logic             clock_o
);

    logic [CNT_W-1:0] period_q, period_n;
    logic [CNT_W-1:0] width_q, width_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [CNT_W-1:0] high_n;
    logic [CNT_W-1:0] load_val;
    logic             restart;
    logic             clock_n;
`ifdef CLOCKS_GEN_PHASE_EN
    logic [CNT_W-1:0] phase_q, phase_n;
`endif

    // Decisions use the values being written this cycle so a strobe and its
    // restart see the new configuration on the same edge.
    always_comb begin
        period_n = period_wstb_i ? period_i : period_q;
        width_n  = width_wstb_i ? width_i : width_q;
        high_n   = CNT_W'(eff_high(CNT_W_MAX'(period_n), CNT_W_MAX'(width_n)));
        restart  = period_wstb_i | width_wstb_i | restart_all_i;
        load_val = '0;
`ifdef CLOCKS_GEN_PHASE_EN
        phase_n  = phase_wstb_i ? phase_i : phase_q;
        restart  = restart | phase_wstb_i;
        if (phase_n < period_n) begin
            load_val = phase_n;
        end
`endif
        cnt_n   = '0;
        clock_n = 1'b0;
        if (enable_i && period_n >= CNT_W'(2)) begin
            if (restart) begin
                cnt_n = load_val;
            end else if (cnt_q >= period_n - CNT_W'(1)) begin
                cnt_n = '0;
            end else begin
                cnt_n = cnt_q + CNT_W'(1);
            end
            clock_n = (cnt_n < high_n);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            period_q <= '0;
            width_q  <= '0;
            cnt_q    <= '0;
            clock_o  <= 1'b0;
        end else begin
            period_q <= period_n;
            width_q  <= width_n;
            cnt_q    <= cnt_n;
            clock_o  <= clock_n;
        end
    end

`ifdef CLOCKS_GEN_PHASE_EN
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_n;
        end
    end
`endif

endmodule

// File: rtl/clocks_gen.sv
// Multi-channel programmable clock generator; optional per-channel start phase
// is enabled by defining CLOCKS_GEN_PHASE_EN.
module clocks_gen
    import clocks_gen_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              enable_i,
    input  logic              sync_i,
    clocks_gen_if.slave       cfg,
    output logic [NUM_CH-1:0] clock_o
);

    logic enable_q;
    logic restart_all;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            enable_q <= 1'b0;
        end else begin
            enable_q <= enable_i;
        end
    end

    // Shared so every channel sees the enable rise on the same edge.
    assign restart_all = sync_i | (enable_i & ~enable_q);

    for (genvar n = 0; n < NUM_CH; n++) begin : g_chan
        clocks_gen_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk_i         (clk_i),
            .reset_n_i     (reset_n_i),
            .enable_i      (enable_i),
            .restart_all_i (restart_all),
            .period_i      (cfg.period_i[n*CNT_W +: CNT_W]),
            .period_wstb_i (cfg.period_wstb_i[n]),
            .width_i       (cfg.width_i[n*CNT_W +: CNT_W]),
            .width_wstb_i  (cfg.width_wstb_i[n]),
`ifdef CLOCKS_GEN_PHASE_EN
            .phase_i       (cfg.phase_i[n*CNT_W +: CNT_W]),
            .phase_wstb_i  (cfg.phase_wstb_i[n]),
`endif
            .clock_o       (clock_o[n])
        );
    end

endmodule
